// File: rtl/bram_dp_if.sv
// bram_dp_if: port A/B access bus plus clear request/busy status for bram_dp
// master: drives requests (i_*) and samples results (o_*); slave: the RAM side
interface bram_dp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              i_a_en, i_a_we, i_b_en, i_b_we, i_clr, o_busy;
  logic [ADDR_W-1:0] i_a_addr, i_b_addr;
  logic [DATA_W-1:0] i_a_data, i_b_data, o_a_data, o_b_data;
  modport master (
    output i_a_en, i_a_we, i_a_addr, i_a_data, i_b_en, i_b_we, i_b_addr, i_b_data, i_clr,
    input  o_a_data, o_b_data, o_busy
  );
  modport slave (
    input  i_a_en, i_a_we, i_a_addr, i_a_data, i_b_en, i_b_we, i_b_addr, i_b_data, i_clr,
    output o_a_data, o_b_data, o_busy
  );
endinterface

// File: rtl/bram_dp.sv
// bram_dp: true dual-port RAM, one clock, read-first/write-first option, optional clear engine (BRAM_DP_CLEAR_EN)
// i_clk: clock; i_rst_n: synchronous active-low reset
// bus (bram_dp_if.slave): ports A/B en/we/addr/data in, registered read data out, i_clr pulse, o_busy
module bram_dp #(
  parameter int    DATA_W    = 8,
  parameter int    ADDR_W    = 16,
  parameter int    SIZE      = 65536,
  parameter string INIT_FILE = "",
  parameter int    RDW_MODE  = 0
) (
  input logic      i_clk,
  input logic      i_rst_n,
  bram_dp_if.slave bus
);
  localparam int IW = SIZE > 1 ? $clog2(SIZE) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(SIZE);
  logic [DATA_W-1:0] mem [SIZE];
  logic              run, a_ok, b_ok, a_wr, b_wr;
  logic [IW-1:0]     a_idx, b_idx;
  logic [DATA_W-1:0] a_old, b_old, a_nxt, b_nxt;
`ifdef BRAM_DP_CLEAR_EN
  typedef enum logic {READY, CLEAR} state_t;
  state_t        state;
  logic [IW-1:0] cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= CLEAR;
      cnt        <= '0;
      bus.o_busy <= 1'b1;
    end else if (state == CLEAR) begin
      cnt <= cnt == IW'(SIZE - 1) ? '0 : cnt + 1'b1;
      if (cnt == IW'(SIZE - 1)) begin
        state      <= READY;
        bus.o_busy <= 1'b0;
      end
    end else if (bus.i_clr) begin
      state      <= CLEAR;
      cnt        <= '0;
      bus.o_busy <= 1'b1;
    end
  end
  assign run = i_rst_n && state == READY;
`else
  assign bus.o_busy = 1'b0;
  assign run = i_rst_n;
`endif
  always_comb begin
    a_ok  = {1'b0, bus.i_a_addr} < LIM;
    b_ok  = {1'b0, bus.i_b_addr} < LIM;
    a_idx = bus.i_a_addr[IW-1:0];
    b_idx = bus.i_b_addr[IW-1:0];
    a_old = a_ok ? mem[a_idx] : '0;
    b_old = b_ok ? mem[b_idx] : '0;
    a_wr  = run && bus.i_a_en && bus.i_a_we && a_ok;
    // port A owns a shared address when both write
    b_wr  = run && bus.i_b_en && bus.i_b_we && b_ok && !(a_wr && bus.i_a_addr == bus.i_b_addr);
    // write-first reports the word actually stored, so a dropped B write shows A's data
    a_nxt = RDW_MODE != 0 && bus.i_a_we ? (a_ok ? bus.i_a_data : '0) : a_old;
    b_nxt = RDW_MODE != 0 && bus.i_b_we ? (!b_ok ? '0 : b_wr ? bus.i_b_data : bus.i_a_data) : b_old;
  end
  always_ff @(posedge i_clk) begin
`ifdef BRAM_DP_CLEAR_EN
    if (i_rst_n && state == CLEAR) mem[cnt] <= '0;
`endif
    if (b_wr) mem[b_idx] <= bus.i_b_data;
    if (a_wr) mem[a_idx] <= bus.i_a_data;
  end
  always_ff @(posedge i_clk) begin
    if (!run) begin
      bus.o_a_data <= '0;
      bus.o_b_data <= '0;
    end else begin
      if (bus.i_a_en) bus.o_a_data <= a_nxt;
      if (bus.i_b_en) bus.o_b_data <= b_nxt;
    end
  end
endmodule

// File: tb/tb_bram_dp.sv
// tb_bram_dp: randomized and directed checks of bram_dp against a word-array reference model
module tb_bram_dp;
`ifdef BRAM_DP_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  int   n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  bram_dp_if #(.DATA_W(8), .ADDR_W(10)) if0 ();
  bram_dp_if #(.DATA_W(8), .ADDR_W(5)) if1 ();
  bram_dp #(.DATA_W(8), .ADDR_W(10), .SIZE(1000), .RDW_MODE(0)) u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
  bram_dp #(.DATA_W(8), .ADDR_W(5), .SIZE(16), .RDW_MODE(1)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
  logic [7:0] m0 [1024];
  bit         k0 [1024];
  logic [7:0] m1 [32];
  bit         k1 [32];
  logic [7:0] x0a, x0b, x1a, x1b;
  bit         k0a, k0b, k1a, k1b;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic idle();
    {if0.i_a_en, if0.i_a_we, if0.i_b_en, if0.i_b_we, if0.i_clr} = '0;
    {if1.i_a_en, if1.i_a_we, if1.i_b_en, if1.i_b_we, if1.i_clr} = '0;
    {if0.i_a_addr, if0.i_b_addr, if0.i_a_data, if0.i_b_data} = '0;
    {if1.i_a_addr, if1.i_b_addr, if1.i_a_data, if1.i_b_data} = '0;
  endtask

  task automatic model_reset();
    {x0a, x0b, x1a, x1b} = '0;
    {k0a, k0b, k1a, k1b} = 4'hf;
    if (CLR_EN) begin
      foreach (m0[i]) begin m0[i] = 8'h00; k0[i] = 1'b1; end
      foreach (m1[i]) begin m1[i] = 8'h00; k1[i] = 1'b1; end
    end
  endtask

  // u0 is read-first: every enabled access reports the word held before the edge
  task automatic op0(bit ea, bit wa, int aa, logic [7:0] da, bit eb, bit wb, int ab, logic [7:0] db);
    bit wra, wrb;
    if0.i_a_en = ea; if0.i_a_we = wa; if0.i_a_addr = 10'(aa); if0.i_a_data = da;
    if0.i_b_en = eb; if0.i_b_we = wb; if0.i_b_addr = 10'(ab); if0.i_b_data = db;
    wra = ea && wa && aa < 1000;
    wrb = eb && wb && ab < 1000 && !(wra && aa == ab);
    if (ea) begin x0a = aa < 1000 ? m0[aa] : 8'h00; k0a = aa >= 1000 || k0[aa]; end
    if (eb) begin x0b = ab < 1000 ? m0[ab] : 8'h00; k0b = ab >= 1000 || k0[ab]; end
    if (wrb) begin m0[ab] = db; k0[ab] = 1'b1; end
    if (wra) begin m0[aa] = da; k0[aa] = 1'b1; end
    @(negedge clk);
  endtask

  // u1 is write-first: a read reports the old word, a write reports the word now stored
  task automatic op1(bit ea, bit wa, int aa, logic [7:0] da, bit eb, bit wb, int ab, logic [7:0] db);
    bit wra, wrb;
    if1.i_a_en = ea; if1.i_a_we = wa; if1.i_a_addr = 5'(aa); if1.i_a_data = da;
    if1.i_b_en = eb; if1.i_b_we = wb; if1.i_b_addr = 5'(ab); if1.i_b_data = db;
    wra = ea && wa && aa < 16;
    wrb = eb && wb && ab < 16 && !(wra && aa == ab);
    if (ea && !wa) begin x1a = aa < 16 ? m1[aa] : 8'h00; k1a = aa >= 16 || k1[aa]; end
    if (eb && !wb) begin x1b = ab < 16 ? m1[ab] : 8'h00; k1b = ab >= 16 || k1[ab]; end
    if (wrb) begin m1[ab] = db; k1[ab] = 1'b1; end
    if (wra) begin m1[aa] = da; k1[aa] = 1'b1; end
    if (ea && wa) begin x1a = m1[aa & 15]; k1a = aa < 16; end
    if (eb && wb) begin x1b = m1[ab & 15]; k1b = ab < 16 && !(wra && aa == ab); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.i_a_en = 1'b1; if0.i_a_we = 1'b1; if0.i_a_addr = 10'd3; if0.i_a_data = 8'h77;
    if0.i_b_en = 1'b1; if0.i_b_addr = 10'd3;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (if0.o_a_data !== 8'h00) begin n_fail++; $display("FAIL reset_u0_a: got %h expected 00", if0.o_a_data); end
    n_chk++; if (if0.o_b_data !== 8'h00) begin n_fail++; $display("FAIL reset_u0_b: got %h expected 00", if0.o_b_data); end
    n_chk++; if (if1.o_a_data !== 8'h00) begin n_fail++; $display("FAIL reset_u1_a: got %h expected 00", if1.o_a_data); end
    n_chk++; if (if1.o_b_data !== 8'h00) begin n_fail++; $display("FAIL reset_u1_b: got %h expected 00", if1.o_b_data); end
    n_chk++; if (if0.o_busy !== CLR_EN) begin n_fail++; $display("FAIL reset_busy0: got %b expected %b", if0.o_busy, CLR_EN); end
    n_chk++; if (if1.o_busy !== CLR_EN) begin n_fail++; $display("FAIL reset_busy1: got %b expected %b", if1.o_busy, CLR_EN); end
    idle();
    model_reset();
  endtask

  task automatic test_release();
    int n0 = 0, n1 = 0, t = 0;
    rst_n = 1'b1;
    while ((if0.o_busy || if1.o_busy) && t < 3000) begin
      n0 += int'(if0.o_busy);
      n1 += int'(if1.o_busy);
      t++;
      @(negedge clk);
    end
    n_chk++; if (n1 != (CLR_EN ? 16 : 0)) begin n_fail++; $display("FAIL release_busy_cycles1: got %0d expected %0d", n1, CLR_EN ? 16 : 0); end
    n_chk++; if (n0 != (CLR_EN ? 1000 : 0)) begin n_fail++; $display("FAIL release_busy_cycles0: got %0d expected %0d", n0, CLR_EN ? 1000 : 0); end
    n_chk++; if ({if0.o_busy, if1.o_busy} !== 2'b00) begin n_fail++; $display("FAIL release_ready: got busy %b%b expected 00", if0.o_busy, if1.o_busy); end
  endtask

  task automatic test_basic();
    op0(1, 1, 16, 8'h5a, 0, 0, 0, 8'h00);
    op0(0, 0, 0, 8'h00, 1, 0, 16, 8'h00);
    n_chk++; if (if0.o_b_data !== 8'h5a) begin n_fail++; $display("FAIL basic_u0_b: got %h expected 5a", if0.o_b_data); end
    op1(1, 1, 4, 8'h3c, 0, 0, 0, 8'h00);
    op1(0, 0, 0, 8'h00, 1, 0, 4, 8'h00);
    n_chk++; if (if1.o_b_data !== 8'h3c) begin n_fail++; $display("FAIL basic_u1_b: got %h expected 3c", if1.o_b_data); end
  endtask

  task automatic test_rdw();
    op0(1, 1, 'h20, 8'h11, 0, 0, 0, 8'h00);
    op0(1, 1, 'h20, 8'h22, 0, 0, 0, 8'h00);
    n_chk++; if (if0.o_a_data !== 8'h11) begin n_fail++; $display("FAIL rdw_read_first: got %h expected 11", if0.o_a_data); end
    op0(1, 0, 'h20, 8'h00, 0, 0, 0, 8'h00);
    n_chk++; if (if0.o_a_data !== 8'h22) begin n_fail++; $display("FAIL rdw_read_after: got %h expected 22", if0.o_a_data); end
    op1(1, 1, 5, 8'h11, 0, 0, 0, 8'h00);
    op1(1, 1, 5, 8'h22, 0, 0, 0, 8'h00);
    n_chk++; if (if1.o_a_data !== 8'h22) begin n_fail++; $display("FAIL rdw_write_first_a: got %h expected 22", if1.o_a_data); end
    op1(0, 0, 0, 8'h00, 1, 1, 6, 8'h33);
    n_chk++; if (if1.o_b_data !== 8'h33) begin n_fail++; $display("FAIL rdw_write_first_b: got %h expected 33", if1.o_b_data); end
  endtask

  task automatic test_collision();
    op0(1, 1, 'h30, 8'haa, 1, 1, 'h30, 8'hbb);
    op0(1, 0, 'h30, 8'h00, 0, 0, 0, 8'h00);
    n_chk++; if (if0.o_a_data !== 8'haa) begin n_fail++; $display("FAIL coll_ww: got %h expected aa", if0.o_a_data); end
    op0(1, 1, 'h31, 8'h44, 0, 0, 0, 8'h00);
    op0(1, 1, 'h31, 8'hcc, 1, 0, 'h31, 8'h00);
    n_chk++; if (if0.o_b_data !== 8'h44) begin n_fail++; $display("FAIL coll_awbr: got %h expected 44", if0.o_b_data); end
    op0(0, 0, 0, 8'h00, 1, 0, 'h31, 8'h00);
    n_chk++; if (if0.o_b_data !== 8'hcc) begin n_fail++; $display("FAIL coll_awbr_after: got %h expected cc", if0.o_b_data); end
    op0(0, 0, 0, 8'h00, 1, 1, 'h32, 8'h55);
    op0(1, 0, 'h32, 8'h00, 1, 1, 'h32, 8'h66);
    n_chk++; if (if0.o_a_data !== 8'h55) begin n_fail++; $display("FAIL coll_bwar: got %h expected 55", if0.o_a_data); end
    op1(1, 1, 3, 8'haa, 1, 1, 3, 8'hbb);
    op1(0, 0, 0, 8'h00, 1, 0, 3, 8'h00);
    n_chk++; if (if1.o_b_data !== 8'haa) begin n_fail++; $display("FAIL coll_ww_u1: got %h expected aa", if1.o_b_data); end
  endtask

  task automatic test_out_of_range();
    op0(1, 1, 0, 8'h3c, 0, 0, 0, 8'h00);
    op0(1, 1, 1000, 8'hff, 0, 0, 0, 8'h00);
    op0(1, 0, 1000, 8'h00, 0, 0, 0, 8'h00);
    n_chk++; if (if0.o_a_data !== 8'h00) begin n_fail++; $display("FAIL oor_read_1000: got %h expected 00", if0.o_a_data); end
    op0(1, 0, 0, 8'h00, 0, 0, 0, 8'h00);
    n_chk++; if (if0.o_a_data !== 8'h3c) begin n_fail++; $display("FAIL oor_addr0_kept: got %h expected 3c", if0.o_a_data); end
    op0(0, 0, 0, 8'h00, 1, 1, 1023, 8'h81);
    op0(0, 0, 0, 8'h00, 1, 0, 1023, 8'h00);
    n_chk++; if (if0.o_b_data !== 8'h00) begin n_fail++; $display("FAIL oor_read_1023: got %h expected 00", if0.o_b_data); end
    op1(1, 1, 5, 8'h12, 0, 0, 0, 8'h00);
    op1(1, 1, 21, 8'hee, 0, 0, 0, 8'h00);
    op1(1, 0, 21, 8'h00, 0, 0, 0, 8'h00);
    n_chk++; if (if1.o_a_data !== 8'h00) begin n_fail++; $display("FAIL oor_read_21: got %h expected 00", if1.o_a_data); end
    op1(1, 0, 5, 8'h00, 0, 0, 0, 8'h00);
    n_chk++; if (if1.o_a_data !== 8'h12) begin n_fail++; $display("FAIL oor_no_alias: got %h expected 12", if1.o_a_data); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int aa = $urandom_range(0, 3) == 0 ? $urandom_range(990, 1023) : $urandom_range(0, 15);
      int ab = $urandom_range(0, 3) == 0 ? $urandom_range(990, 1023) : $urandom_range(0, 15);
      op0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), aa, 8'($urandom),
          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ab, 8'($urandom));
      if (k0a) begin
        n_chk++; if (if0.o_a_data !== x0a) begin n_fail++; $display("FAIL rand_a[%0d]: got %h expected %h", i, if0.o_a_data, x0a); end
      end
      if (k0b) begin
        n_chk++; if (if0.o_b_data !== x0b) begin n_fail++; $display("FAIL rand_b[%0d]: got %h expected %h", i, if0.o_b_data, x0b); end
      end
    end
    idle();
  endtask

  task automatic test_reset_keep();
    op0(1, 1, 5, 8'h5a, 0, 0, 0, 8'h00);
    op0(1, 0, 5, 8'h00, 0, 0, 0, 8'h00);
    n_chk++; if (if0.o_a_data !== 8'h5a) begin n_fail++; $display("FAIL keep_pre: got %h expected 5a", if0.o_a_data); end
    rst_n = 1'b0;
    if0.i_a_en = 1'b1; if0.i_a_we = 1'b1; if0.i_a_addr = 10'd5; if0.i_a_data = 8'h77;
    @(negedge clk);
    n_chk++; if (if0.o_a_data !== 8'h00) begin n_fail++; $display("FAIL keep_reset_out: got %h expected 00", if0.o_a_data); end
    idle();
    model_reset();
    test_release();
    op0(1, 0, 5, 8'h00, 0, 0, 0, 8'h00);
    n_chk++; if (if0.o_a_data !== x0a) begin n_fail++; $display("FAIL keep_after: got %h expected %h", if0.o_a_data, x0a); end
    idle();
  endtask

`ifdef BRAM_DP_CLEAR_EN
  task automatic test_clear();
    int n = 0;
    op1(1, 1, 2, 8'h99, 0, 0, 0, 8'h00);
    idle();
    if1.i_clr = 1'b1;
    @(negedge clk);
    if1.i_clr = 1'b0;
    while (if1.o_busy && n < 100) begin
      n++;
      if1.i_clr = n == 8;
      {if1.i_a_en, if1.i_a_we, if1.i_b_en} = n == 10 ? 3'b111 : 3'b000;
      if1.i_a_addr = 5'd2; if1.i_a_data = 8'h55; if1.i_b_addr = 5'd2;
      @(negedge clk);
      if (n == 10) begin
        n_chk++; if (if1.o_a_data !== 8'h00) begin n_fail++; $display("FAIL clear_lock_a: got %h expected 00", if1.o_a_data); end
        n_chk++; if (if1.o_b_data !== 8'h00) begin n_fail++; $display("FAIL clear_lock_b: got %h expected 00", if1.o_b_data); end
      end
    end
    idle();
    n_chk++; if (n != 16) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 16", n); end
    model_reset();
    for (int i = 0; i < 16; i++) begin
      op1(1, 0, i, 8'h00, 1, 0, 15 - i, 8'h00);
      n_chk++; if (if1.o_a_data !== 8'h00) begin n_fail++; $display("FAIL clear_word_a[%0d]: got %h expected 00", i, if1.o_a_data); end
      n_chk++; if (if1.o_b_data !== 8'h00) begin n_fail++; $display("FAIL clear_word_b[%0d]: got %h expected 00", 15 - i, if1.o_b_data); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    if1.i_clr = 1'b1;
    @(negedge clk);
    if1.i_clr = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (if1.o_busy !== 1'b1) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 1", if1.o_busy); end
    n_chk++; if ({if1.o_a_data, if1.o_b_data} !== 16'h0000) begin n_fail++; $display("FAIL mid_reset_out: got %h expected 0000", {if1.o_a_data, if1.o_b_data}); end
    model_reset();
    test_release();
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_release();
    test_basic();
    test_rdw();
    test_collision();
    test_out_of_range();
    test_random();
    test_reset_keep();
`ifdef BRAM_DP_CLEAR_EN
    test_clear();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
